// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg: shared types and constants for the instruction fetch unit.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          STALE_W          = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_entry_t;

    typedef struct packed {
        logic redirect;
        logic alloc;
        logic fill;
        logic drop;
        logic pop;
    } control_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer: in-order fetch buffer with response fill and stale-drop tracking.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alloc_i,
    input  logic [31:0] alloc_pc_i,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_data_i,
    input  logic        redirect_i,
    input  logic        out_ready_i,
    output logic        full_o,
    output logic        out_valid_o,
    output logic [31:0] out_instruction_o,
    output logic [31:0] out_pc_o
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    fetch_entry_t       entry_q [DEPTH];
    logic [PW:0]        head_q;
    logic [PW:0]        fill_q;
    logic [PW:0]        tail_q;
    logic [STALE_W-1:0] stale_q;
    logic [STALE_W-1:0] stale_d;
    logic [PW:0]        count;
    logic [PW:0]        unfilled;
    fetch_entry_t       head;
    control_t           ctl;

    // Unfilled entries always form the contiguous run between fill_q and tail_q.
    assign count    = tail_q - head_q;
    assign unfilled = tail_q - fill_q;
    assign full_o   = (count == (PW+1)'(DEPTH));
    assign head     = entry_q[head_q[PW-1:0]];

    assign out_valid_o       = head.filled & ~redirect_i;
    assign out_instruction_o = out_valid_o ? head.instr : '0;
    assign out_pc_o          = out_valid_o ? head.pc    : '0;

    always_comb begin
        ctl          = '0;
        ctl.redirect = redirect_i;
        ctl.pop      = out_valid_o & out_ready_i;
        ctl.alloc    = alloc_i & ~redirect_i;
        ctl.drop     = rsp_valid_i & (stale_q != '0);
        ctl.fill     = rsp_valid_i & ~redirect_i & (stale_q == '0) & (unfilled != '0);
        stale_d      = stale_q;
        // Everything still owed by memory becomes stale, less a response landing now.
        if (redirect_i) begin
            stale_d = stale_q + STALE_W'(unfilled)
                    - STALE_W'(rsp_valid_i & ((stale_q != '0) | (unfilled != '0)));
        end else if (ctl.drop) begin
            stale_d = stale_q - STALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
            stale_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            stale_q <= stale_d;
            if (ctl.redirect) begin
                head_q <= tail_q;
                fill_q <= tail_q;
                for (int i = 0; i < DEPTH; i++) begin
                    entry_q[i].filled <= 1'b0;
                end
            end else begin
                if (ctl.alloc) begin
                    entry_q[tail_q[PW-1:0]] <= '{pc: alloc_pc_i, instr: '0, filled: 1'b0};
                    tail_q                  <= tail_q + PTR_ONE;
                end
                if (ctl.fill) begin
                    entry_q[fill_q[PW-1:0]].instr  <= rsp_data_i;
                    entry_q[fill_q[PW-1:0]].filled <= 1'b1;
                    fill_q                         <= fill_q + PTR_ONE;
                end
                if (ctl.pop) begin
                    entry_q[head_q[PW-1:0]].filled <= 1'b0;
                    head_q                         <= head_q + PTR_ONE;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch: PC register and instruction-memory request logic feeding fetch_buffer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        run_q;
    logic        buf_full;
    logic        req_fire;

    // run_q holds requests off until the first edge after reset is released.
    assign imem_req_valid = run_q & ~buf_full & ~redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            run_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            run_q <= 1'b1;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk               (clk),
        .rst_n             (rst_n),
        .alloc_i           (req_fire),
        .alloc_pc_i        (pc_q),
        .rsp_valid_i       (imem_rsp_valid),
        .rsp_data_i        (imem_rsp_data),
        .redirect_i        (redirect_valid),
        .out_ready_i       (out_ready),
        .full_o            (buf_full),
        .out_valid_o       (out_valid),
        .out_instruction_o (out_instruction),
        .out_pc_o          (out_pc)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// ---------------------------------------------------------------------------
// tb_fetch: queue-based reference model and in-order memory model driving fetch.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } ment_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ment_t       bq[$];
    mreq_t       mq[$];
    logic [31:0] m_pc;
    bit          m_run;
    int          m_stale;

    int  cyc;
    int  n_chk;
    int  n_fail;
    int  mem_lat;
    bit  inj;

    bit          e_req_v, e_out_v;
    logic [31:0] e_addr, e_out_pc, e_out_ins;
    logic        s_req_v, s_out_v;
    logic [31:0] s_addr, s_out_pc, s_out_ins;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        bq.delete();
        m_pc    = RST_PC;
        m_run   = 1'b0;
        m_stale = 0;
    endfunction

    function automatic void model_expect();
        e_req_v   = (rst_n === 1'b1) && m_run && (bq.size() < DEPTH) && !redirect_valid;
        e_addr    = m_pc;
        e_out_v   = (rst_n === 1'b1) && !redirect_valid && (bq.size() > 0) && bq[0].filled;
        e_out_pc  = e_out_v ? bq[0].pc    : 32'h0;
        e_out_ins = e_out_v ? bq[0].instr : 32'h0;
    endfunction

    // Applies one clock edge of the specified behaviour to the queue model.
    function automatic void model_update();
        int    unf;
        ment_t t;
        if (rst_n !== 1'b1) return;
        unf = 0;
        foreach (bq[i]) if (!bq[i].filled) unf++;
        if (redirect_valid) begin
            m_stale = m_stale + unf;
            if (imem_rsp_valid && (m_stale > 0)) m_stale--;
            bq.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (imem_rsp_valid) begin
                if (m_stale > 0) begin
                    m_stale--;
                end else begin
                    for (int i = 0; i < bq.size(); i++) begin
                        if (!bq[i].filled) begin
                            t        = bq[i];
                            t.instr  = imem_rsp_data;
                            t.filled = 1'b1;
                            bq[i]    = t;
                            break;
                        end
                    end
                end
            end
            if (e_out_v && out_ready) void'(bq.pop_front());
            if (e_req_v && imem_req_ready) begin
                t = '{pc: m_pc, instr: 32'h0, filled: 1'b0};
                bq.push_back(t);
                m_pc = m_pc + 32'd4;
            end
        end
        m_run = 1'b1;
    endfunction

    // One cycle: inputs are already driven just after a negedge.
    task automatic step();
        bit          dut_acc;
        logic [31:0] dut_addr;
        mreq_t       r;
        if (rst_n !== 1'b1) begin
            model_reset();
            mq.delete();
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (inj) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if ((rst_n === 1'b1) && (mq.size() > 0) && (mq[0].due <= cyc)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        #2;
        model_expect();
        s_req_v   = imem_req_valid;
        s_addr    = imem_req_addr;
        s_out_v   = out_valid;
        s_out_pc  = out_pc;
        s_out_ins = out_instruction;
        chk("req_valid", 32'(s_req_v), 32'(e_req_v));
        chk("req_addr", s_addr, e_addr);
        chk("out_valid", 32'(s_out_v), 32'(e_out_v));
        chk("out_pc", s_out_pc, e_out_pc);
        chk("out_instruction", s_out_ins, e_out_ins);
        dut_acc  = s_req_v & imem_req_ready;
        dut_addr = s_addr;
        @(posedge clk);
        if (dut_acc && (rst_n === 1'b1)) begin
            r.addr = dut_addr;
            r.due  = cyc + mem_lat;
            mq.push_back(r);
        end
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick(input bit rdy, input bit ordy, input bit rv = 1'b0,
                        input logic [31:0] rpc = 32'h0);
        imem_req_ready = rdy;
        out_ready      = ordy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1'b0, 1'b0);
        chk("rst_req_valid", 32'(s_req_v), 32'h0);
        chk("rst_req_addr", s_addr, RST_PC);
        chk("rst_out_valid", 32'(s_out_v), 32'h0);
        chk("rst_out_pc", s_out_pc, 32'h0);
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b1);
    endtask

    task automatic wait_first_out(input string name, input logic [31:0] exp_pc);
        bit          seen;
        logic [31:0] first;
        seen  = 1'b0;
        first = 32'h0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick(1'b1, 1'b1);
            if (s_out_v) begin
                seen  = 1'b1;
                first = s_out_pc;
            end
        end
        chk({name, "_seen"}, 32'(seen), 32'h1);
        chk({name, "_pc"}, first, exp_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", n_chk);
        $fatal(1);
    end

    initial begin
        int acc;
        cyc            = 0;
        n_chk          = 0;
        n_fail         = 0;
        mem_lat        = 1;
        inj            = 1'b0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        model_reset();
        @(negedge clk);

        // Sequential fetch with 1-cycle memory.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b1);
            if (k < 3) begin
                chk("seq_req_valid", 32'(s_req_v), 32'h1);
                chk("seq_req_addr", s_addr, 32'(4 * k));
            end
            if (k < 2) chk("seq_no_early_out", 32'(s_out_v), 32'h0);
            if (k >= 2 && k < 5) begin
                chk("seq_out_valid", 32'(s_out_v), 32'h1);
                chk("seq_out_pc", s_out_pc, 32'(4 * (k - 2)));
            end
        end

        // Decode stalled: buffer fills to DEPTH, head held stable.
        do_reset();
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b0);
            if (s_req_v) acc++;
            if (k >= 2) begin
                chk("stall_head_valid", 32'(s_out_v), 32'h1);
                chk("stall_head_pc", s_out_pc, 32'h0);
                chk("stall_head_ins", s_out_ins, mem_word(32'h0));
            end
        end
        chk("stall_accepts", 32'(acc), 32'h4);
        chk("stall_req_dropped", 32'(s_req_v), 32'h0);
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1);

        // Redirect with three responses outstanding.
        do_reset();
        mem_lat = 6;
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        chk("redir_no_req", 32'(s_req_v), 32'h0);
        chk("redir_no_out", 32'(s_out_v), 32'h0);
        mem_lat = 1;
        wait_first_out("redir_first", 32'h0000_0100);

        // Redirect coinciding with a response and a pop.
        do_reset();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("same_cyc_redir_out", 32'(s_out_v), 32'h0);
        tick(1'b1, 1'b1);
        chk("same_cyc_empty_after", 32'(s_out_v), 32'h0);
        wait_first_out("same_cyc_first", 32'h0000_0200);

        // Misaligned redirect near the top of the address space wraps to zero.
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        tick(1'b1, 1'b1);
        chk("wrap_req_valid", 32'(s_req_v), 32'h1);
        chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b1);
        chk("wrap_addr_zero", s_addr, 32'h0000_0000);
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b1);

        // Reset mid-stream with responses in flight, then stray responses.
        do_reset();
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1);
        mem_lat = 3;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("pre_rst_out_valid", 32'(s_out_v), 32'h1);
        rst_n = 1'b0;
        tick(1'b0, 1'b0);
        chk("mid_rst_out_valid", 32'(s_out_v), 32'h0);
        chk("mid_rst_out_pc", s_out_pc, 32'h0);
        chk("mid_rst_out_ins", s_out_ins, 32'h0);
        chk("mid_rst_req_valid", 32'(s_req_v), 32'h0);
        tick(1'b0, 1'b0);
        rst_n   = 1'b1;
        mem_lat = 1;
        inj     = 1'b1;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        inj = 1'b0;
        tick(1'b0, 1'b1);
        chk("stray_ignored", 32'(s_out_v), 32'h0);
        wait_first_out("post_rst_first", 32'h0000_0000);
        chk("post_rst_ins", s_out_ins, mem_word(32'h0));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            mem_lat = $urandom_range(1, 4);
            rpc     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
            rst_n   = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            tick($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 4, rpc);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick(1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
